// File: rtl/pacman_pkg.sv
// Shared tile codes, map geometry, writer state encoding and address helper
// for the pacman map writer.
package pacman_pkg;

    localparam int MAP_W_DEFAULT = 40;
    localparam int MAP_H_DEFAULT = 30;
    localparam int X_BITS        = 6;
    localparam int Y_BITS        = 5;
    localparam int ADDR_BITS     = X_BITS + Y_BITS;

    typedef enum logic [3:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PILL   = 4'd2,
        PACMAN = 4'd3
    } tile_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_ERASE,
        S_DRAW,
        S_DONE,
        S_COOL,
        S_ABORT
    } writer_state_t;

    // Map RAM is row-major with a 64-tile row pitch: address = {y, x}.
    function automatic logic [ADDR_BITS-1:0] map_addr(input logic [X_BITS-1:0] x,
                                                      input logic [Y_BITS-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/move_pacer.sv
// Loadable down-counter that holds the writer in cooldown after each commit;
// zero is asserted while the count register is at zero.
module move_pacer
    import pacman_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/pacman_map_writer.sv
// Applies a requested pacman move to the map RAM: reads the destination tile,
// erases the current tile, draws pacman at the destination, then cools down.
module pacman_map_writer
    import pacman_pkg::*;
#(
    parameter int MAP_W      = MAP_W_DEFAULT,
    parameter int MAP_H      = MAP_H_DEFAULT,
    parameter int MOVE_DELAY = 16
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [X_BITS-1:0]     curr_pacman_x,
    input  logic [Y_BITS-1:0]     curr_pacman_y,
    input  logic [X_BITS-1:0]     next_pacman_x,
    input  logic [Y_BITS-1:0]     next_pacman_y,
    output logic                  done,
    output logic                  busy,
    output logic                  pill_eaten,
    output logic                  wall_hit,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic                  ram_we,
    output logic [3:0]            ram_wdata,
    input  logic [3:0]            ram_rdata
);

    localparam int CNT_W = (MOVE_DELAY > 1) ? $clog2(MOVE_DELAY) : 1;
    localparam logic [X_BITS:0] X_LIMIT = (X_BITS + 1)'(MAP_W);
    localparam logic [Y_BITS:0] Y_LIMIT = (Y_BITS + 1)'(MAP_H);

    writer_state_t       state_reg;
    logic [X_BITS-1:0]   cx_reg;
    logic [Y_BITS-1:0]   cy_reg;
    logic [X_BITS-1:0]   nx_reg;
    logic [Y_BITS-1:0]   ny_reg;
    logic                cool_zero;
    logic                move_request;
    logic                out_of_range;

    assign move_request = ({next_pacman_x, next_pacman_y} != {curr_pacman_x, curr_pacman_y});
    // Wrap-around from the controller (e.g. x=0 stepping left gives 63) lands here too.
    assign out_of_range = ({1'b0, next_pacman_x} >= X_LIMIT) ||
                          ({1'b0, next_pacman_y} >= Y_LIMIT);

    move_pacer #(
        .WIDTH (CNT_W)
    ) u_pacer (
        .clk        (CLOCK_50),
        .rst_n      (reset),
        .load       (state_reg == S_DONE),
        .load_value (CNT_W'(MOVE_DELAY - 1)),
        .dec        (state_reg == S_COOL),
        .zero       (cool_zero)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            cx_reg     <= '0;
            cy_reg     <= '0;
            nx_reg     <= '0;
            ny_reg     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            pill_eaten <= 1'b0;
            wall_hit   <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= EMPTY;
        end else begin
            done       <= 1'b0;
            pill_eaten <= 1'b0;
            wall_hit   <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (move_request) begin
                        cx_reg <= curr_pacman_x;
                        cy_reg <= curr_pacman_y;
                        nx_reg <= next_pacman_x;
                        ny_reg <= next_pacman_y;
                        busy   <= 1'b1;
                        if (out_of_range) begin
                            wall_hit  <= 1'b1;
                            state_reg <= S_ABORT;
                        end else begin
                            ram_addr  <= map_addr(next_pacman_x, next_pacman_y);
                            state_reg <= S_READ;
                        end
                    end
                end

                S_READ: state_reg <= S_CHECK;

                S_CHECK: begin
                    if (ram_rdata == WALL) begin
                        wall_hit  <= 1'b1;
                        state_reg <= S_ABORT;
                    end else begin
                        pill_eaten <= (ram_rdata == PILL);
                        ram_addr   <= map_addr(cx_reg, cy_reg);
                        ram_wdata  <= EMPTY;
                        ram_we     <= 1'b1;
                        state_reg  <= S_ERASE;
                    end
                end

                S_ERASE: begin
                    ram_addr  <= map_addr(nx_reg, ny_reg);
                    ram_wdata <= PACMAN;
                    state_reg <= S_DRAW;
                end

                S_DRAW: begin
                    ram_we    <= 1'b0;
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end

                S_DONE: state_reg <= S_COOL;

                S_COOL: begin
                    if (cool_zero) begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                // Rejected move: wait for the controller to withdraw the request.
                S_ABORT: begin
                    if (!move_request) begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    ram_we    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
